pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - five-stage valid/allowin handshake with RAW scoreboard and branch squash
// Optional bypass selection when PIPE_HAZARD_FORWARD_EN is defined.
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_src1_en,
  input  logic       id_src2_en,
  input  logic [4:0] id_src1,
  input  logic [4:0] id_src2,
  input  logic       id_gr_we,
  input  logic [4:0] id_dest,
  input  logic       id_is_load,
  input  logic       id_br_taken,
  input  logic       mem_stall_req,
  output logic [4:0] stage_valid,
  output logic [4:0] stage_allowin,
  output logic [4:0] stage_ready_go,
  output logic       pc_we,
  output logic       id_cancel,
  output logic [1:0] fwd_sel1,
  output logic [1:0] fwd_sel2
);

  // Stage bits: 4 IF, 3 ID, 2 EXE, 1 MEM, 0 WB. Scoreboard index: 2 EXE, 1 MEM, 0 WB.
  logic [4:0]      valid_q, valid_d;
  logic [2:0][4:0] dest_q, dest_d;
  logic [2:0]      we_q, we_d;
  logic [2:0]      ld_q, ld_d;

  logic [2:0] match1, match2;
  logic       raw_stall;
  logic [4:0] ready_go, allowin;
  logic       cancel;

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      match1[s] = id_src1_en & (id_src1 != 5'd0) & valid_q[s] & we_q[s] & (dest_q[s] == id_src1);
      match2[s] = id_src2_en & (id_src2 != 5'd0) & valid_q[s] & we_q[s] & (dest_q[s] == id_src2);
    end
  end

`ifdef PIPE_HAZARD_FORWARD_EN
  // Only a load still in EXE cannot be bypassed; youngest producer wins.
  assign raw_stall = valid_q[3] & ld_q[2] & (match1[2] | match2[2]);
  assign fwd_sel1  = match1[2] ? 2'd1 : match1[1] ? 2'd2 : match1[0] ? 2'd3 : 2'd0;
  assign fwd_sel2  = match2[2] ? 2'd1 : match2[1] ? 2'd2 : match2[0] ? 2'd3 : 2'd0;
`else
  assign raw_stall = valid_q[3] & ((|match1) | (|match2));
  assign fwd_sel1  = 2'd0;
  assign fwd_sel2  = 2'd0;
`endif

  assign ready_go   = valid_q & {1'b1, ~raw_stall, 1'b1, ~mem_stall_req, 1'b1};
  assign allowin[0] = 1'b1;
  assign allowin[1] = ~valid_q[1] | (ready_go[1] & allowin[0]);
  assign allowin[2] = ~valid_q[2] | (ready_go[2] & allowin[1]);
  assign allowin[3] = ~valid_q[3] | (ready_go[3] & allowin[2]);
  assign allowin[4] = ~valid_q[4] | (ready_go[4] & allowin[3]);

  // A stalled ID has ready_go low, so a branch is only honoured on its issue cycle.
  assign cancel = valid_q[3] & id_br_taken & ready_go[3] & allowin[2];

  always_comb begin
    valid_d = valid_q;
    dest_d  = dest_q;
    we_d    = we_q;
    ld_d    = ld_q;
    if (allowin[4]) valid_d[4] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (allowin[i]) valid_d[i] = valid_q[i+1] & ready_go[i+1];
    end
    if (cancel) valid_d[3] = 1'b0;
    if (allowin[2]) begin
      dest_d[2] = id_dest;
      we_d[2]   = id_gr_we;
      ld_d[2]   = id_is_load;
    end
    for (int s = 0; s < 2; s++) begin
      if (allowin[s]) begin
        dest_d[s] = dest_q[s+1];
        we_d[s]   = we_q[s+1];
        ld_d[s]   = ld_q[s+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dest_q  <= '0;
      we_q    <= '0;
      ld_q    <= '0;
    end else begin
      valid_q <= valid_d;
      dest_q  <= dest_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
    end
  end

  logic unused_ld;
  assign unused_ld = ^ld_q;

  assign stage_valid    = valid_q;
  assign stage_allowin  = allowin;
  assign stage_ready_go = ready_go;
  assign pc_we          = allowin[4];
  assign id_cancel      = cancel;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       id_src1_en, id_src2_en;
  logic [4:0] id_src1, id_src2;
  logic       id_gr_we;
  logic [4:0] id_dest;
  logic       id_is_load, id_br_taken, mem_stall_req;
  logic [4:0] stage_valid, stage_allowin, stage_ready_go;
  logic       pc_we, id_cancel;
  logic [1:0] fwd_sel1, fwd_sel2;

  int n_checks = 0;
  int n_err    = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_src1_en(id_src1_en), .id_src2_en(id_src2_en),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_gr_we(id_gr_we), .id_dest(id_dest),
    .id_is_load(id_is_load), .id_br_taken(id_br_taken),
    .mem_stall_req(mem_stall_req),
    .stage_valid(stage_valid), .stage_allowin(stage_allowin),
    .stage_ready_go(stage_ready_go), .pc_we(pc_we), .id_cancel(id_cancel),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2)
  );

  always #5 clk = ~clk;

`ifdef PIPE_HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_and_check(input string tag);
    repeat (4) tick();
    #1 chk(tag, stage_valid, 5'b11111);
  endtask

  initial begin
    logic [4:0] ramp [1:5];
    ramp[1] = 5'b10000; ramp[2] = 5'b11000; ramp[3] = 5'b11100;
    ramp[4] = 5'b11110; ramp[5] = 5'b11111;

    reset = 1'b1; id_src1_en = 0; id_src2_en = 0; id_src1 = 0; id_src2 = 0;
    id_gr_we = 0; id_dest = 0; id_is_load = 0; id_br_taken = 0; mem_stall_req = 0;

    repeat (2) tick();
    chk("rst_valid", stage_valid, 5'b00000);
    chk("rst_ready_go", stage_ready_go, 5'b00000);
    chk("rst_allowin", stage_allowin, 5'b11111);
    chk("rst_pc_we", {4'b0, pc_we}, 5'd1);
    chk("rst_cancel", {4'b0, id_cancel}, 5'd0);
    chk("rst_fwd", {1'b0, fwd_sel1, fwd_sel2}, 5'd0);

    reset = 1'b0;
    #1 chk("ramp0", stage_valid, 5'b00000);
    chk("ramp0_pc_we", {4'b0, pc_we}, 5'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("ramp%0d", k), stage_valid, ramp[k]);
      chk($sformatf("ramp%0d_pc_we", k), {4'b0, pc_we}, 5'd1);
    end

    // EXE writes r5, ID reads r5 on src1
    id_gr_we = 1; id_dest = 5'd5;
    tick();
    id_gr_we = 0; id_dest = 0; id_src1_en = 1; id_src1 = 5'd5;
    #1;
    if (FWD) begin
      chk("raw_fwd_sel1", {3'b0, fwd_sel1}, 5'd1);
      chk("raw_fwd_pc_we", {4'b0, pc_we}, 5'd1);
    end else begin
      chk("raw_ready_go", stage_ready_go, 5'b10111);
      chk("raw_allowin", stage_allowin, 5'b00111);
      chk("raw_c1_pc_we", {4'b0, pc_we}, 5'd0);
      tick();
      chk("raw_c2_valid", stage_valid, 5'b11011);
      chk("raw_c2_pc_we", {4'b0, pc_we}, 5'd0);
      tick();
      chk("raw_c3_valid", stage_valid, 5'b11001);
      chk("raw_c3_pc_we", {4'b0, pc_we}, 5'd0);
      tick();
      chk("raw_c4_valid", stage_valid, 5'b11000);
      chk("raw_c4_ready_go", stage_ready_go, 5'b11000);
      chk("raw_c4_pc_we", {4'b0, pc_we}, 5'd1);
    end
    id_src1_en = 0; id_src1 = 0;
    fill_and_check("raw_refill");

    // load-use on src2: one bubble then bypass from MEM
    if (FWD) begin
      id_gr_we = 1; id_is_load = 1; id_dest = 5'd7;
      tick();
      id_gr_we = 0; id_is_load = 0; id_dest = 0; id_src2_en = 1; id_src2 = 5'd7;
      #1 chk("ld_stall_pc_we", {4'b0, pc_we}, 5'd0);
      chk("ld_stall_ready_go", stage_ready_go, 5'b10111);
      tick();
      chk("ld_issue_valid", stage_valid, 5'b11011);
      chk("ld_issue_pc_we", {4'b0, pc_we}, 5'd1);
      chk("ld_issue_fwd_sel2", {3'b0, fwd_sel2}, 5'd2);
      id_src2_en = 0; id_src2 = 0;
      fill_and_check("ld_refill");
    end

    // r0 never matches
    id_gr_we = 1; id_dest = 5'd0;
    tick();
    id_gr_we = 0; id_src1_en = 1; id_src1 = 5'd0;
    #1 chk("r0_pc_we", {4'b0, pc_we}, 5'd1);
    chk("r0_ready_go", stage_ready_go, 5'b11111);
    chk("r0_fwd_sel1", {3'b0, fwd_sel1}, 5'd0);
    id_src1_en = 0;

    // src2 match only counts when src2 is enabled
    id_gr_we = 1; id_dest = 5'd9;
    tick();
    id_gr_we = 0; id_dest = 0; id_src2 = 5'd9; id_src2_en = 0;
    #1 chk("src2_off_pc_we", {4'b0, pc_we}, 5'd1);
    id_src2_en = 1;
    #1 chk("src2_on_pc_we", {4'b0, pc_we}, FWD ? 5'd1 : 5'd0);
    chk("src2_on_fwd_sel2", {3'b0, fwd_sel2}, FWD ? 5'd1 : 5'd0);
    id_src2_en = 0; id_src2 = 0;
    fill_and_check("src2_refill");

    // taken branch squashes the IF shadow
    id_br_taken = 1;
    #1 chk("br_cancel", {4'b0, id_cancel}, 5'd1);
    tick();
    id_br_taken = 0;
    #1 chk("br_valid_after", stage_valid, 5'b10111);
    chk("br_cancel_after", {4'b0, id_cancel}, 5'd0);
    fill_and_check("br_refill");

    // branch while ID is stalled is ignored
    id_gr_we = 1; id_dest = 5'd5;
    tick();
    id_gr_we = 0; id_dest = 0; id_src1_en = 1; id_src1 = 5'd5; id_br_taken = 1;
    #1 chk("br_stall_cancel", {4'b0, id_cancel}, FWD ? 5'd1 : 5'd0);
    id_br_taken = 0; id_src1_en = 0; id_src1 = 0;
    fill_and_check("br_stall_refill");

    // MEM stall two cycles on a full pipe
    mem_stall_req = 1;
    #1 chk("ms1_pc_we", {4'b0, pc_we}, 5'd0);
    chk("ms1_allowin", stage_allowin, 5'b00001);
    chk("ms1_ready_go", stage_ready_go, 5'b11101);
    tick();
    chk("ms2_valid", stage_valid, 5'b11110);
    chk("ms2_pc_we", {4'b0, pc_we}, 5'd0);
    chk("ms2_allowin", stage_allowin, 5'b00001);
    tick();
    mem_stall_req = 0;
    #1 chk("ms3_valid", stage_valid, 5'b11110);
    chk("ms3_pc_we", {4'b0, pc_we}, 5'd1);
    chk("ms3_allowin", stage_allowin, 5'b11111);
    tick();
    chk("ms4_valid", stage_valid, 5'b11111);

    // RAW and MEM stall together, then reset mid-stall
    id_gr_we = 1; id_dest = 5'd5;
    tick();
    id_gr_we = 0; id_dest = 0; id_src1_en = 1; id_src1 = 5'd5; mem_stall_req = 1;
    #1 chk("both_ready_go", stage_ready_go, FWD ? 5'b11101 : 5'b10101);
    chk("both_allowin", stage_allowin, 5'b00001);
    tick();
    chk("both_valid", stage_valid, 5'b11110);
    reset = 1;
    tick();
    chk("rst2_valid", stage_valid, 5'b00000);
    chk("rst2_allowin", stage_allowin, 5'b11111);
    chk("rst2_fwd_sel1", {3'b0, fwd_sel1}, 5'd0);
    chk("rst2_pc_we", {4'b0, pc_we}, 5'd1);
    reset = 0; mem_stall_req = 0; id_src1_en = 0; id_src1 = 0;
    #1 chk("rst2_after_valid", stage_valid, 5'b00000);
    tick();
    chk("rst2_first_valid", stage_valid, 5'b10000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
